// File: rtl/sm_conv_pkg.sv
// Shared types and constants for the sign-magnitude / two's-complement
// converter.
//   sm_mode_e : per-transaction conversion direction
//   STAT_W    : width of the optional statistics counters
// Optional feature macro: SM_CONV_STATS_EN (used by sign_magnitude_conv).
package sm_conv_pkg;

  typedef enum logic {
    SM_TC2SM = 1'b0,  // two's complement -> sign-magnitude
    SM_SM2TC = 1'b1   // sign-magnitude   -> two's complement
  } sm_mode_e;

  localparam int STAT_W = 16;

endpackage

// File: rtl/sm_pipe_stage.sv
// One valid/ready register stage with a W-bit payload.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid_i/in_ready_o  : upstream handshake
//   in_data_i              : upstream payload
//   out_valid_o/out_ready_i: downstream handshake
//   out_data_o             : registered payload
// The stage accepts whenever it is empty or its content is leaving this
// cycle, so a full stage can pop and push in the same cycle.
module sm_pipe_stage
  import sm_conv_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         advance;

  assign advance = !valid_q || out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (advance) begin
      valid_q <= in_valid_i;
      // Payload only moves with a real transaction so idle cycles leave it alone.
      if (in_valid_i) begin
        data_q <= in_data_i;
      end
    end
  end

  assign in_ready_o  = advance;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/sign_magnitude_conv.sv
// Two-stage pipelined converter between two's-complement and sign-magnitude
// formats, direction selected per transaction by in_mode.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   in_valid/in_ready        : input handshake
//   in_mode                  : 0 = two's complement -> sign-magnitude,
//                              1 = sign-magnitude -> two's complement
//   in_data                  : operand
//   out_valid/out_ready      : output handshake
//   out_sign, out_data       : converted result
//   out_neg_zero             : mode 1 input was -0
//   stat_count, stat_neg     : accepted / negative-result counters
//                              (only when SM_CONV_STATS_EN is defined)
// S1 registers the operand plus decoded sign and magnitude-zero flag; the
// conditional negation sits between S1 and S2, and S2 holds the outputs.
module sign_magnitude_conv
  import sm_conv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_neg_zero
`ifdef SM_CONV_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_count,
  output logic [STAT_W-1:0] stat_neg
`endif
);

  localparam int S1_W = WIDTH + 3;  // {mode, sign, mag_zero, operand}
  localparam int S2_W = WIDTH + 2;  // {neg_zero, sign, data}

  logic [S1_W-1:0]  s1_in_d;
  logic [S1_W-1:0]  s1_pl_q;
  logic             s1_valid;
  logic             s2_ready;
  logic [S2_W-1:0]  s2_in_d;
  logic [S2_W-1:0]  s2_pl_q;

  // m == 0 looks only at the magnitude field; in mode 0 the flag is unused.
  assign s1_in_d = {in_mode, in_data[WIDTH-1], (in_data[WIDTH-2:0] == '0), in_data};

  sm_pipe_stage #(.W(S1_W)) u_s1 (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (s1_in_d),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_ready),
    .out_data_o (s1_pl_q)
  );

  sm_mode_e         s1_mode;
  logic             s1_sign;
  logic             s1_mzero;
  logic [WIDTH-1:0] s1_op;
  logic [WIDTH-1:0] mag_src;
  logic [WIDTH-1:0] conv_data;
  logic             conv_sign;
  logic             conv_nz;

  assign s1_mode  = sm_mode_e'(s1_pl_q[S1_W-1]);
  assign s1_sign  = s1_pl_q[S1_W-2];
  assign s1_mzero = s1_pl_q[S1_W-3];
  assign s1_op    = s1_pl_q[WIDTH-1:0];

  always_comb begin
    mag_src   = s1_op;
    conv_sign = s1_sign;
    conv_nz   = 1'b0;
    if (s1_mode == SM_SM2TC) begin
      mag_src   = {1'b0, s1_op[WIDTH-2:0]};
      conv_sign = s1_sign && !s1_mzero;
      conv_nz   = s1_sign && s1_mzero;
    end
    // Negation wraps modulo 2^WIDTH: the most-negative input maps onto itself,
    // which read unsigned is exactly its magnitude. -0 negates to 0.
    conv_data = s1_sign ? (~mag_src + {{(WIDTH-1){1'b0}}, 1'b1}) : mag_src;
  end

  assign s2_in_d = {conv_nz, conv_sign, conv_data};

  sm_pipe_stage #(.W(S2_W)) u_s2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_ready),
    .in_data_i  (s2_in_d),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s2_pl_q)
  );

  assign out_neg_zero = s2_pl_q[S2_W-1];
  assign out_sign     = s2_pl_q[S2_W-2];
  assign out_data     = s2_pl_q[WIDTH-1:0];

`ifdef SM_CONV_STATS_EN
  logic [STAT_W-1:0] stat_count_q;
  logic [STAT_W-1:0] stat_neg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_count_q <= '0;
      stat_neg_q   <= '0;
    end else begin
      if (in_valid && in_ready && (stat_count_q != '1)) begin
        stat_count_q <= stat_count_q + 1'b1;
      end
      if (out_valid && out_ready && out_sign && (stat_neg_q != '1)) begin
        stat_neg_q <= stat_neg_q + 1'b1;
      end
    end
  end

  assign stat_count = stat_count_q;
  assign stat_neg   = stat_neg_q;
`endif

endmodule

// File: tb/tb_sign_magnitude_conv.sv
// Bench for sign_magnitude_conv (WIDTH = 16). Also exercises the counters
// when SM_CONV_STATS_EN is defined.
module tb_sign_magnitude_conv;

  typedef logic [17:0] res_t;  // {neg_zero, sign, data}

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_mode = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [15:0] out_data;
  logic        out_neg_zero;
`ifdef SM_CONV_STATS_EN
  logic [15:0] stat_count;
  logic [15:0] stat_neg;
`endif

  sign_magnitude_conv #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sign    (out_sign),
    .out_data    (out_data),
    .out_neg_zero(out_neg_zero)
`ifdef SM_CONV_STATS_EN
    ,
    .stat_count  (stat_count),
    .stat_neg    (stat_neg)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  res_t exp_q[$];
  res_t seen_q[$];
  int   seen_cyc[$];

  // Reference: plain integer arithmetic on the numeric value.
  function automatic res_t model(input logic mode, input logic [15:0] d);
    int          v;
    logic        sg;
    logic        nz;
    logic [15:0] data;
    if (mode == 1'b0) begin
      v  = int'($signed(d));
      sg = (v < 0);
      if (sg) v = -v;
      data = v[15:0];
      nz   = 1'b0;
    end else begin
      v = int'(d[14:0]);
      if (d[15]) v = -v;
      data = v[15:0];
      sg   = (v < 0);
      nz   = d[15] && (d[14:0] == 15'd0);
    end
    return {nz, sg, data};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Compare process: every output transfer against the model queue, plus
  // stability of outputs while stalled.
  res_t prev_out;
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", {out_valid, out_neg_zero, out_sign, out_data}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_output actual=%0h required=none", {out_neg_zero, out_sign, out_data});
        end else begin
          res_t e;
          e = exp_q.pop_front();
          check("model_out", {out_neg_zero, out_sign, out_data}, e);
        end
        seen_q.push_back({out_neg_zero, out_sign, out_data});
        seen_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_mode, in_data));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_neg_zero, out_sign, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_seen(input int n);
    for (int g = 0; g < 40 && seen_q.size() < n; g++) tick();
  endtask

  // Single transaction with latency and literal result check.
  task automatic one(input logic mode, input logic [15:0] d, input res_t lit, input string nm);
    int c0;
    int n;
    check({nm, "_model"}, model(mode, d), lit);
    out_ready = 1'b1;
    in_mode   = mode;
    in_data   = d;
    in_valid  = 1'b1;
    @(negedge clk);
    check({nm, "_accept"}, in_ready, 1);
    c0 = cyc;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check({nm, "_latency"}, cyc - c0, 2);
    check({nm, "_result"}, {out_neg_zero, out_sign, out_data}, lit);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int idx;
    logic [15:0] pat;
    logic [16:0] vec [8];

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid_during", out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", {out_valid, out_sign, out_neg_zero, out_data}, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SM_CONV_STATS_EN
    check("rst_stats", {stat_count, stat_neg}, 0);
`endif
    tick();

    // Directed single transactions.
    one(1'b0, 16'hFFFB, {1'b0, 1'b1, 16'h0005}, "m0_neg5");
    one(1'b0, 16'h8000, {1'b0, 1'b1, 16'h8000}, "m0_most_neg");
    one(1'b0, 16'h0000, {1'b0, 1'b0, 16'h0000}, "m0_zero");
    one(1'b1, 16'h8005, {1'b0, 1'b1, 16'hFFFB}, "m1_neg5");
    one(1'b1, 16'h8000, {1'b1, 1'b0, 16'h0000}, "m1_neg_zero");
    one(1'b1, 16'h7FFF, {1'b0, 1'b0, 16'h7FFF}, "m1_max");

    // Backpressure: out_ready low for 4 cycles while streaming 1..4.
    seen_q.delete();
    seen_cyc.delete();
    out_ready = 1'b0;
    acc = 0;
    idx = 1;
    in_mode = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = idx[15:0];
      @(negedge clk);
      if (in_ready) begin
        acc++;
        idx++;
      end
      tick();
    end
    check("bp_accepts_when_full", acc, 2);
    check("bp_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    in_data = idx[15:0];
    @(negedge clk);
    check("bp_pop_push_same_cycle", in_ready, 1);
    if (in_ready) idx++;
    tick();
    for (int g = 0; g < 10 && idx <= 4; g++) begin
      in_data = idx[15:0];
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    wait_seen(4);
    check("bp_count", seen_q.size(), 4);
    for (int k = 0; k < 4 && k < seen_q.size(); k++)
      check("bp_order", seen_q[k], {2'b00, 16'(k + 1)});

    // Alternating modes on 0x8001, one per cycle.
    seen_q.delete();
    seen_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_mode  = i[0];
      in_data  = 16'h8001;
      in_valid = 1'b1;
      @(negedge clk);
      check("alt_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    wait_seen(8);
    check("alt_count", seen_q.size(), 8);
    for (int k = 0; k < 8 && k < seen_q.size(); k++) begin
      check("alt_value", seen_q[k], (k % 2 == 0) ? {2'b01, 16'h7FFF} : {2'b01, 16'hFFFF});
      if (k > 0) check("alt_throughput", seen_cyc[k] - seen_cyc[k-1], 1);
    end

    // Vector table under a fixed out_ready pattern; checked by the model.
    vec[0] = {1'b0, 16'h7FFF};
    vec[1] = {1'b0, 16'h0001};
    vec[2] = {1'b0, 16'hFFFF};
    vec[3] = {1'b1, 16'h0001};
    vec[4] = {1'b1, 16'hFFFF};
    vec[5] = {1'b1, 16'h0000};
    vec[6] = {1'b0, 16'h8001};
    vec[7] = {1'b1, 16'h7FFF};
    pat = 16'b1011_0010_1101_0110;
    seen_q.delete();
    seen_cyc.delete();
    idx = 0;
    for (int g = 0; g < 60 && idx < 8; g++) begin
      out_ready = pat[g % 16];
      in_valid  = 1'b1;
      in_mode   = vec[idx][16];
      in_data   = vec[idx][15:0];
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_seen(8);
    check("tbl_count", seen_q.size(), 8);
    if (seen_q.size() == 8) begin
      check("tbl_m0_minus1", seen_q[2], {2'b01, 16'h0001});
      check("tbl_m1_minus_max", seen_q[4], {2'b01, 16'h8001});
    end

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    in_mode   = 1'b0;
    in_data   = 16'hFFFE;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("rst_mid_loaded", out_valid, 1);
    #2 reset = 1'b1;
    #1 check("rst_mid_async_drop", out_valid, 0);
    tick();
    reset = 1'b0;
    seen_q.delete();
    seen_cyc.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    check("rst_mid_no_stale", seen_q.size(), 0);
    check("rst_mid_ready", in_ready, 1);

`ifdef SM_CONV_STATS_EN
    check("stats_after_reset", {stat_count, stat_neg}, 0);
    out_ready = 1'b1;
    in_mode   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: in_data = 16'hFFFF;
        1: in_data = 16'h0001;
        2: in_data = 16'h8000;
        3: in_data = 16'h0002;
        default: in_data = 16'hFFFE;
      endcase
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    check("stats_count", stat_count, 5);
    check("stats_neg", stat_neg, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
